gf2_poly_div: RTL

//  Sequential GF(2) polynomial long divider, the inverse of the 59x59 Karatsuba product path.

---
 rtl/gf233_pkg.sv | 22 ++
 rtl/gf2_div_step.sv | 26 ++
 rtl/gf2_poly_div.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gf233_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gf233_pkg                                                                  |
// | Shared widths and divider state encoding for the GF(2^233) datapath.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gf233_pkg;

  localparam int GF_DW = 118;  // unreduced 59x59 product width
  localparam int GF_VW = 59;   // multiplier operand / divisor width
  localparam int GF_M  = 233;  // field degree

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NORM   = 3'd1,
    ST_DIV    = 3'd2,
    ST_UNNORM = 3'd3,
    ST_DONE   = 3'd4
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/gf2_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gf2_div_step                                                               |
// | One combinational GF(2) long-division step against a normalised divisor.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gf2_div_step
  import gf233_pkg::*;
#(
  parameter int VW = GF_VW
) (
  input  logic [VW-2:0] rem,
  input  logic          in_bit,
  input  logic [VW-2:0] divisor_low,
  output logic [VW-2:0] rem_next,
  output logic          q_bit
);

  // The divisor's leading one is implicit, so the bit leaving R is the quotient bit.
  always_comb begin
    q_bit    = rem[VW-2];
    rem_next = {rem[VW-3:0], in_bit} ^ ({(VW-1){q_bit}} & divisor_low);
  end

endmodule
`default_nettype wire

// File: rtl/gf2_poly_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gf2_poly_div                                                               |
// | Bit-serial GF(2) polynomial divider: d = q*b ^ r, one quotient bit/clock.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gf2_poly_div
  import gf233_pkg::*;
#(
  parameter int DW = GF_DW,
  parameter int VW = GF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-2:0] remainder,
  output logic          div_zero
);

  localparam int              c_CW     = $clog2(DW + VW);
  localparam logic [c_CW-1:0] c_DW_CNT = c_CW'(DW);
  localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

  div_state_t      r_state;
  div_state_t      w_next_state;
  logic [DW-1:0]   r_a;
  logic [VW-1:0]   r_b;
  logic [VW-2:0]   r_rem;
  logic [DW-1:0]   r_quo;
  logic [c_CW-1:0] r_s;
  logic [c_CW-1:0] r_cnt;
  logic            r_div_zero;
  logic [VW-2:0]   w_step_rem;
  logic            w_step_qbit;

  gf2_div_step #(
    .VW (VW)
  ) u_step (
    .rem         (r_rem),
    .in_bit      (r_a[DW-1]),
    .divisor_low (r_b[VW-2:0]),
    .rem_next    (w_step_rem),
    .q_bit       (w_step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = (divisor == '0) ? ST_DONE : ST_NORM;
        end
      end
      ST_NORM: begin
        if (r_b[VW-1]) begin
          w_next_state = ST_DIV;
        end
      end
      ST_DIV: begin
        // Leave on the edge that performs the final step.
        if (r_cnt == c_ONE) begin
          w_next_state = ST_UNNORM;
        end
      end
      ST_UNNORM: begin
        if (r_s == '0) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_s        <= '0;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= dividend;
            r_b        <= divisor;
            r_rem      <= '0;
            r_quo      <= '0;
            r_s        <= '0;
            r_div_zero <= (divisor == '0);
          end
        end
        ST_NORM: begin
          // Shift the divisor up until its leading one sits in the MSB; s remembers by how much.
          if (r_b[VW-1]) begin
            r_cnt <= c_DW_CNT + r_s;
          end else begin
            r_b <= r_b << 1;
            r_s <= r_s + c_ONE;
          end
        end
        ST_DIV: begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[DW-2:0], w_step_qbit};
          r_a   <= r_a << 1;
          r_cnt <= r_cnt - c_ONE;
        end
        ST_UNNORM: begin
          // R holds r*x^s after the division pass; undo the normalisation.
          if (r_s != '0) begin
            r_rem <= r_rem >> 1;
            r_s   <= r_s - c_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign div_zero  = r_div_zero;

endmodule
`default_nettype wire
